// File: rtl/homomorphic_decrypt_if.sv
// Valid/ready bus between a ciphertext producer, the LWE decryptor and the
// plaintext consumer. The master side drives ciphertexts, the key and
// out_ready; the slave side is the decryptor.
interface homomorphic_decrypt_if #(
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int DIMENSION        = 1
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]   ciphertext;
  logic [DIMENSION-1:0][CIPHERTEXT_WIDTH-1:0] secret_key;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [PLAINTEXT_WIDTH-1:0]             plaintext;

  modport master (
    output in_valid, ciphertext, secret_key, out_ready,
    input  in_ready, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, secret_key, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/homomorphic_decrypt.sv
// Sequential LWE decryptor: m = round((b - <a,s>) * p / q) mod p.
// One multiply-accumulate per clock, then a rounding decode, then the
// plaintext is held until the consumer takes it.
module homomorphic_decrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int DIMENSION          = 1,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int BIG_N              = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  homomorphic_decrypt_if.slave  bus
);
  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int IDX_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIMENSION - 1);
  // Half of one plaintext step in the ciphertext domain (q / 2p).
  localparam logic [CW-1:0]    HALF_STEP = CW'(1) << (CW - PW - 1);

  // Moduli must be powers of two matching the widths; BIG_N is carried only
  // for compatibility with sibling stages.
  if (PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH) ||
      CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH) ||
      CIPHERTEXT_WIDTH <= PLAINTEXT_WIDTH || DIMENSION < 1 || BIG_N < 0) begin : g_param_check
    $error("homomorphic_decrypt: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, MAC, DECODE, OUT} state_t;

  state_t                      state, state_next;
  logic [DIMENSION-1:0][CW-1:0] a_reg;
  logic [CW-1:0]               b_reg;
  logic [CW-1:0]               acc;
  logic [IDX_W-1:0]            idx;
  logic [PW-1:0]               plaintext_reg;
  logic                        out_valid_reg;

  // Wrapping difference, add half a step (wrapping so values just below q
  // round to 0), keep the top PW bits.
  function automatic logic [PW-1:0] round_decode(input logic [CW-1:0] b_val,
                                                 input logic [CW-1:0] acc_val);
    logic [CW-1:0] diff;
    logic [CW-1:0] rnd;
    diff = b_val - acc_val;
    rnd  = diff + HALF_STEP;
    return PW'(rnd >> (CW - PW));
  endfunction

  // Product at full 2*CW width, reduced mod q together with the sum.
  function automatic logic [CW-1:0] mac_step(input logic [CW-1:0] acc_val,
                                             input logic [CW-1:0] a_val,
                                             input logic [CW-1:0] s_val);
    return acc_val + CW'({{CW{1'b0}}, a_val} * {{CW{1'b0}}, s_val});
  endfunction

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.plaintext = plaintext_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = MAC;
      MAC:     if (idx == LAST_IDX) state_next = DECODE;
      DECODE:  state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch ciphertext, accumulate <a,s>, decode and hold plaintext
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      idx           <= '0;
      plaintext_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.ciphertext[DIMENSION-1:0];
            b_reg <= bus.ciphertext[DIMENSION];
            acc   <= '0;
            idx   <= '0;
          end
        end
        MAC: begin
          acc <= mac_step(acc, a_reg[idx], bus.secret_key[idx]);
          idx <= idx + 1'b1;
        end
        DECODE: begin
          plaintext_reg <= round_decode(b_reg, acc);
          out_valid_reg <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_homomorphic_decrypt.sv
// Bench for homomorphic_decrypt: a DIMENSION=1 instance for the directed
// table and random traffic, and a DIMENSION=4 instance for the chained-adder
// scenario, random traffic and mid-operation reset.
module tb_homomorphic_decrypt;
  localparam int CW = 10;
  localparam int PW = 6;

  typedef int vec4_t [4];
  typedef struct {
    int a;
    int s;
    int b;
    int exp;
    int backp;
    bit pulse;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n4;
  always #5 clk = ~clk;

  homomorphic_decrypt_if #(.CIPHERTEXT_WIDTH(CW), .PLAINTEXT_WIDTH(PW), .DIMENSION(1)) bus1();
  homomorphic_decrypt_if #(.CIPHERTEXT_WIDTH(CW), .PLAINTEXT_WIDTH(PW), .DIMENSION(4)) bus4();

  homomorphic_decrypt #(
    .PLAINTEXT_MODULUS(64), .PLAINTEXT_WIDTH(PW), .DIMENSION(1),
    .CIPHERTEXT_MODULUS(1024), .CIPHERTEXT_WIDTH(CW), .BIG_N(30)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  homomorphic_decrypt #(
    .PLAINTEXT_MODULUS(64), .PLAINTEXT_WIDTH(PW), .DIMENSION(4),
    .CIPHERTEXT_MODULUS(1024), .CIPHERTEXT_WIDTH(CW), .BIG_N(30)
  ) dut4 (.clk(clk), .rst_n(rst_n4), .bus(bus4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: m = round((b - <a,s>) * p / q) mod p, in plain integer math.
  function automatic int model(input int dim, input vec4_t a, input vec4_t s, input int b);
    int dot;
    int diff;
    dot = 0;
    for (int i = 0; i < dim; i++) dot += a[i] * s[i];
    diff = ((b - dot) % 1024 + 1024) % 1024;
    return ((diff * 64 + 512) / 1024) % 64;
  endfunction

  function automatic logic [31:0] ov(input int dim);
    return (dim == 1) ? 32'(bus1.out_valid) : 32'(bus4.out_valid);
  endfunction
  function automatic logic [31:0] ir(input int dim);
    return (dim == 1) ? 32'(bus1.in_ready) : 32'(bus4.in_ready);
  endfunction
  function automatic logic [31:0] pt(input int dim);
    return (dim == 1) ? 32'(bus1.plaintext) : 32'(bus4.plaintext);
  endfunction

  task automatic drive_in(input int dim, input bit v, input vec4_t a, input vec4_t s, input int b);
    if (dim == 1) begin
      bus1.in_valid      = v;
      bus1.ciphertext[0] = CW'(a[0]);
      bus1.ciphertext[1] = CW'(b);
      bus1.secret_key[0] = CW'(s[0]);
    end else begin
      for (int i = 0; i < 4; i++) begin
        bus4.ciphertext[i] = CW'(a[i]);
        bus4.secret_key[i] = CW'(s[i]);
      end
      bus4.ciphertext[4] = CW'(b);
      bus4.in_valid      = v;
    end
  endtask

  task automatic set_or(input int dim, input bit v);
    if (dim == 1) bus1.out_ready = v;
    else          bus4.out_ready = v;
  endtask

  // One full transaction: accept, scramble inputs, wait for out_valid,
  // optional backpressure (with optional ignored in_valid pulses), drain.
  task automatic xact(input int dim, input vec4_t a, input vec4_t s, input int b,
                      input int exp, input int backp, input bit pulse, input string nm);
    int    cnt;
    vec4_t junk;
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, ir(dim), 1);
    drive_in(dim, 1'b1, a, s, b);
    set_or(dim, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) junk[i] = int'($urandom_range(0, 1023));
    drive_in(dim, pulse, junk, s, int'($urandom_range(0, 1023)));
    chk({nm, "_in_ready_busy"}, ir(dim), 0);
    cnt = 1;
    while (ov(dim) !== 1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, "_latency"}, cnt, dim + 2);
    chk({nm, "_plaintext"}, pt(dim), exp);
    for (int i = 0; i < backp; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, ov(dim), 1);
      chk({nm, "_hold_pt"}, pt(dim), exp);
      chk({nm, "_hold_busy"}, ir(dim), 0);
    end
    drive_in(dim, 1'b0, junk, s, 0);
    set_or(dim, 1'b1);
    @(negedge clk);
    set_or(dim, 1'b0);
    chk({nm, "_valid_drop"}, ov(dim), 0);
    chk({nm, "_in_ready_back"}, ir(dim), 1);
  endtask

  vec_t  tbl [7];
  vec4_t a4, s4, z4;
  int    b4, e4;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{5,    3, 127,  7,  0, 1'b0};
    tbl[1] = '{5,    3, 132,  7,  1, 1'b0};
    tbl[2] = '{5,    3, 122,  7,  0, 1'b1};
    tbl[3] = '{1000, 3, 936,  63, 2, 1'b0};
    tbl[4] = '{0,    3, 1020, 0,  0, 1'b0};
    tbl[5] = '{0,    3, 8,    1,  0, 1'b0};
    tbl[6] = '{0,    3, 7,    0,  5, 1'b1};
    z4 = '{0, 0, 0, 0};

    rst_n  = 1'b0;
    rst_n4 = 1'b0;
    drive_in(1, 1'b0, z4, z4, 0);
    drive_in(4, 1'b0, z4, z4, 0);
    set_or(1, 1'b0);
    set_or(4, 1'b0);
    #12;
    chk("rst_in_ready", ir(1), 1);
    chk("rst_out_valid", ov(1), 0);
    chk("rst_plaintext", pt(1), 0);
    chk("rst4_in_ready", ir(4), 1);
    chk("rst4_out_valid", ov(4), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    rst_n4 = 1'b1;

    // Directed table on DIMENSION=1
    for (int i = 0; i < 7; i++) begin
      a4 = '{tbl[i].a, 0, 0, 0};
      s4 = '{tbl[i].s, 0, 0, 0};
      xact(1, a4, s4, tbl[i].b, tbl[i].exp, tbl[i].backp, tbl[i].pulse, $sformatf("tbl%0d", i));
    end

    // Sum of two ciphertexts (encrypting 5 and 9) through DIMENSION=4
    a4 = '{2, 2, 2, 2};
    s4 = '{1, 2, 3, 4};
    xact(4, a4, s4, 244, 14, 1, 1'b0, "chain4");

    // Reset during MAC discards the in-flight ciphertext
    @(negedge clk);
    drive_in(4, 1'b1, a4, s4, 244);
    @(negedge clk);
    drive_in(4, 1'b0, a4, s4, 244);
    @(negedge clk);
    rst_n4 = 1'b0;
    #1;
    chk("midrst_in_ready", ir(4), 1);
    chk("midrst_out_valid", ov(4), 0);
    chk("midrst_plaintext", pt(4), 0);
    @(negedge clk);
    rst_n4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_output", ov(4), 0);
    end
    xact(4, a4, s4, 244, 14, 0, 1'b0, "after_rst4");

    // Random traffic against the reference model
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 4; j++) begin
        a4[j] = (j == 0) ? int'($urandom_range(0, 1023)) : 0;
        s4[j] = (j == 0) ? int'($urandom_range(0, 1023)) : 0;
      end
      b4 = int'($urandom_range(0, 1023));
      e4 = model(1, a4, s4, b4);
      xact(1, a4, s4, b4, e4, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rnd1_%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        a4[j] = int'($urandom_range(0, 1023));
        s4[j] = int'($urandom_range(0, 1023));
      end
      b4 = int'($urandom_range(0, 1023));
      e4 = model(4, a4, s4, b4);
      xact(4, a4, s4, b4, e4, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rnd4_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
